// File: rtl/tone_request_arbiter.sv
// tone_request_arbiter: fixed-priority owner of the sine-table tone path with a phase accumulator and inter-tone gap.
// Define TONE_ARB_PREEMPT_EN to let a higher-priority request cut the current tone short.
module tone_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_SIZE  = 8,
  parameter int PHASE_W     = 16,
  parameter int DUR_W       = 16,
  parameter int GAP_SAMPLES = 64
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        sample_tick,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*PHASE_W-1:0]  freq_step,
  input  logic [NUM_REQ*DUR_W-1:0]    duration,
  output logic [NUM_REQ-1:0]          grant,
  output logic [COUNT_SIZE-1:0]       ADDR,
  output logic                        playing,
  output logic [$clog2(NUM_REQ)-1:0]  active_id,
  output logic [NUM_REQ-1:0]          pending
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GAP_SAMPLES + 2);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state, state_n;
  logic [PHASE_W-1:0] phase, phase_n, step_r, step_n, freq_sel;
  logic [DUR_W-1:0] rem, rem_n, dur_sel;
  logic [GW-1:0] gap, gap_n;
  logic [NUM_REQ-1:0] grant_n, pending_n;
  logic [IW-1:0] sel, active_n;
  logic playing_n, take, preempt, tick_play, fin;
  always_comb begin
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (pending[i]) sel = IW'(i);
  end
  assign freq_sel = freq_step[int'(sel)*PHASE_W +: PHASE_W];
  assign dur_sel  = duration[int'(sel)*DUR_W +: DUR_W];
  // A grant in flight blocks preemption so grant never pulses on consecutive cycles.
`ifdef TONE_ARB_PREEMPT_EN
  assign preempt = state == PLAY && !(|grant) && |pending && sel < active_id;
`else
  assign preempt = 1'b0;
`endif
  assign take      = (state == IDLE && |pending) || preempt;
  assign tick_play = state == PLAY && sample_tick && !preempt;
  assign fin       = tick_play && rem <= DUR_W'(1);
  assign ADDR      = phase[PHASE_W-1 -: COUNT_SIZE];
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE)      state_n = |pending ? PLAY : IDLE;
    else if (state == PLAY) state_n = fin ? (GAP_SAMPLES > 0 ? GAP : IDLE) : PLAY;
    else                    state_n = (sample_tick && gap <= GW'(1)) ? IDLE : GAP;
  end
  always_comb begin
    grant_n   = take ? NUM_REQ'(1) << sel : '0;
    pending_n = (pending & ~grant_n) | req;
    phase_n   = (take || fin) ? '0 : tick_play ? phase + step_r : phase;
    rem_n     = take ? (dur_sel == '0 ? DUR_W'(1) : dur_sel) : tick_play ? rem - DUR_W'(1) : rem;
    step_n    = take ? freq_sel : step_r;
    active_n  = take ? sel : active_id;
    playing_n = take ? 1'b1 : fin ? 1'b0 : playing;
    gap_n     = fin ? GW'(GAP_SAMPLES) : (state == GAP && sample_tick) ? gap - GW'(1) : gap;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      phase     <= '0;
      step_r    <= '0;
      rem       <= '0;
      gap       <= '0;
      grant     <= '0;
      pending   <= '0;
      active_id <= '0;
      playing   <= 1'b0;
    end else begin
      phase     <= phase_n;
      step_r    <= step_n;
      rem       <= rem_n;
      gap       <= gap_n;
      grant     <= grant_n;
      pending   <= pending_n;
      active_id <= active_n;
      playing   <= playing_n;
    end
  end
endmodule

// File: tb/tb_tone_request_arbiter.sv
// tb_tone_request_arbiter: directed and randomized checks of tone_request_arbiter against a tick-counting model.
module tb_tone_request_arbiter;
  localparam int N = 4, CS = 8, PW = 16, DW = 16, GAP = 2;
  logic clk = 0, resetN = 0, sample_tick = 0;
  logic [N-1:0] req = '0;
  logic [N*PW-1:0] freq_step = '0;
  logic [N*DW-1:0] duration = '0;
  logic [N-1:0] grant, pending;
  logic [CS-1:0] ADDR;
  logic playing;
  logic [1:0] active_id;
  int checks = 0, errors = 0;

  tone_request_arbiter #(.NUM_REQ(N), .COUNT_SIZE(CS), .PHASE_W(PW), .DUR_W(DW), .GAP_SAMPLES(GAP)) dut (
    .clk(clk), .resetN(resetN), .sample_tick(sample_tick), .req(req), .freq_step(freq_step),
    .duration(duration), .grant(grant), .ADDR(ADDR), .playing(playing), .active_id(active_id), .pending(pending));

  always #5 clk = ~clk;

  // Model: a tone is k ticks into its length; ADDR is the top byte of k*step mod 2^16.
  int m_mode, m_id, m_len, m_done, m_gap, mk;
  logic [N-1:0] m_pend, m_grant, mg;
  logic [15:0] m_step;
  logic m_play, mstart;

  function automatic int lowest(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return N;
  endfunction

  function automatic logic [7:0] exp_addr();
    logic [63:0] p;
    p = 64'(m_done) * 64'(m_step);
    return m_mode == 1 ? p[15:8] : 8'h00;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_mode = 0; m_pend = '0; m_grant = '0; m_id = 0; m_len = 0;
      m_done = 0; m_gap = 0; m_step = '0; m_play = 0;
    end else begin
      mg = '0; mk = lowest(m_pend); mstart = 0;
      if (m_mode == 0) mstart = m_pend != '0;
      else if (m_mode == 1) begin
`ifdef TONE_ARB_PREEMPT_EN
        mstart = m_pend != '0 && m_grant == '0 && mk < m_id;
`endif
        if (!mstart && sample_tick) begin
          m_done++;
          if (m_done >= m_len) begin
            m_play = 0; m_done = 0; m_gap = GAP; m_mode = GAP > 0 ? 2 : 0;
          end
        end
      end else if (sample_tick) begin
        m_gap--;
        if (m_gap == 0) m_mode = 0;
      end
      if (mstart) begin
        mg = N'(1) << mk; m_mode = 1; m_id = mk; m_play = 1; m_done = 0;
        m_step = freq_step[mk*PW +: PW];
        m_len = duration[mk*DW +: DW] == '0 ? 1 : int'(duration[mk*DW +: DW]);
      end
      m_pend = (m_pend & ~mg) | req;
      m_grant = mg;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetN) begin
      chk("cmp_ADDR", ADDR, exp_addr());
      chk("cmp_grant", grant, m_grant);
      chk("cmp_playing", playing, m_play);
      chk("cmp_active_id", active_id, m_id);
      chk("cmp_pending", pending, m_pend);
      chk("cmp_grant_onehot", $onehot0(grant), 1);
    end
  end

  task automatic cyc(input logic t, input logic [N-1:0] r);
    sample_tick = t; req = r;
    @(negedge clk);
  endtask

  task automatic setf(input int i, input logic [15:0] f, input logic [15:0] d);
    freq_step[i*PW +: PW] = f;
    duration[i*DW +: DW] = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_mode != 0 || m_pend != '0) && n < 300) begin cyc(1, '0); n++; end
    cyc(0, '0);
    chk("idle_timeout", n < 300, 1);
  endtask

  initial begin
    logic [N-1:0] r;
    logic t;
    repeat (2) @(negedge clk);
    chk("rst_ADDR", ADDR, 0); chk("rst_grant", grant, 0); chk("rst_playing", playing, 0);
    chk("rst_active_id", active_id, 0); chk("rst_pending", pending, 0);
    resetN = 1;
    @(negedge clk);
    // Single tone with a 2-tick gap
    setf(2, 16'h0400, 3);
    cyc(0, 4'b0100); chk("st_pending", pending, 4'b0100); chk("st_nogrant", grant, 0);
    cyc(0, 4'b0000); chk("st_grant", grant, 4'b0100); chk("st_id", active_id, 2);
    chk("st_play", playing, 1); chk("st_a0", ADDR, 8'h00);
    cyc(1, 4'b0000); chk("st_a1", ADDR, 8'h04); chk("st_gpulse", grant, 0);
    cyc(1, 4'b0000); chk("st_a2", ADDR, 8'h08);
    cyc(1, 4'b0000); chk("st_a3", ADDR, 8'h00); chk("st_gap_play", playing, 0);
    cyc(1, 4'b0000); cyc(1, 4'b0000);
    cyc(0, 4'b0100); cyc(0, 4'b0000); chk("st_regrant", grant, 4'b0100);
    wait_idle();
    // Phase wrap-around
    setf(1, 16'h8000, 4);
    cyc(0, 4'b0010); cyc(0, 4'b0000); chk("wr_grant", grant, 4'b0010); chk("wr_a0", ADDR, 8'h00);
    cyc(1, 4'b0000); chk("wr_a1", ADDR, 8'h80);
    cyc(1, 4'b0000); chk("wr_a2", ADDR, 8'h00);
    cyc(1, 4'b0000); chk("wr_a3", ADDR, 8'h80); chk("wr_play", playing, 1);
    cyc(1, 4'b0000); chk("wr_end", ADDR, 8'h00); chk("wr_end_play", playing, 0);
    wait_idle();
    // Simultaneous requests: 1 first, 3 only after tone 1 and the gap
    setf(1, 16'h0100, 2); setf(3, 16'h0200, 2);
    cyc(0, 4'b1010); chk("sim_pend0", pending, 4'b1010);
    cyc(0, 4'b0000); chk("sim_grant1", grant, 4'b0010); chk("sim_pend1", pending, 4'b1000);
    cyc(1, 4'b0000); chk("sim_pend2", pending, 4'b1000);
    cyc(1, 4'b0000); chk("sim_gap", playing, 0);
    cyc(1, 4'b0000); chk("sim_wait", grant, 0);
    cyc(1, 4'b0000); chk("sim_wait2", grant, 0); chk("sim_pend3", pending, 4'b1000);
    cyc(0, 4'b0000); chk("sim_grant3", grant, 4'b1000); chk("sim_id3", active_id, 3);
    wait_idle();
    // Duration 0, step 0: one-tick tone
    setf(0, 16'h0000, 16'h0000);
    cyc(0, 4'b0001); cyc(0, 4'b0000); chk("d0_grant", grant, 4'b0001); chk("d0_play", playing, 1);
    cyc(0, 4'b0000); chk("d0_hold", playing, 1); chk("d0_addr", ADDR, 0);
    cyc(1, 4'b0000); chk("d0_end", playing, 0); chk("d0_grant_once", grant, 0);
    wait_idle();
    // Preemption of tone 3 by requester 0
    setf(3, 16'h1000, 10); setf(0, 16'h0800, 3);
    cyc(0, 4'b1000); cyc(0, 4'b0000); chk("pe_grant3", grant, 4'b1000);
    cyc(1, 4'b0000); chk("pe_a1", ADDR, 8'h10);
    cyc(0, 4'b0001); chk("pe_pend", pending, 4'b0001);
    cyc(0, 4'b0000);
`ifdef TONE_ARB_PREEMPT_EN
    chk("pe_grant0", grant, 4'b0001); chk("pe_id", active_id, 0);
    chk("pe_addr", ADDR, 8'h00); chk("pe_play", playing, 1); chk("pe_pend_clr", pending, 0);
`else
    chk("np_grant", grant, 0); chk("np_id", active_id, 3);
    chk("np_addr", ADDR, 8'h10); chk("np_pend", pending, 4'b0001);
`endif
    wait_idle();
    // Asynchronous reset mid-tone
    setf(2, 16'h2000, 8);
    cyc(0, 4'b0100); cyc(0, 4'b0000); cyc(1, 4'b0000); cyc(0, 4'b0001);
    chk("rs_pre_play", playing, 1);
    #2 resetN = 0; req = '0;
    #1 chk("rs_ADDR", ADDR, 0); chk("rs_grant", grant, 0); chk("rs_play", playing, 0); chk("rs_pend", pending, 0);
    @(negedge clk); resetN = 1;
    setf(1, 16'h0100, 1);
    cyc(0, 4'b0010); cyc(0, 4'b0000); chk("rs_idle_grant", grant, 4'b0010);
    wait_idle();
    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      t = $urandom_range(0, 2) == 0;
      r = $urandom_range(0, 5) == 0 ? N'($urandom) : '0;
      for (int i = 0; i < N; i++)
        if (!m_pend[i] && !r[i] && $urandom_range(0, 3) == 0)
          setf(i, $urandom_range(0, 4) == 0 ? 16'h0 : 16'($urandom), 16'($urandom_range(0, 6)));
      if ($urandom_range(0, 799) == 0) begin
        #2 resetN = 0;
        #1 resetN = 1;
      end
      cyc(t, r);
    end
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
